// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared constants, state type and gap helper for the Flappy Bird engine
package flappy_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int SPAWN_X   = 640;
    localparam int INIT_GAP  = 240;
    localparam int SCORE_MAX = 999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Map the low LFSR byte onto a gap centre in 120..359
    function automatic logic [8:0] gap_from_lfsr(input logic [7:0] g);
        if (g < 8'd240) begin
            return 9'd120 + {1'b0, g};
        end
        return 9'd120 + {1'b0, g} - 9'd128;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_q
);

    logic [15:0] lfsr_d;

    // Right shift; the bit falling out of position 0 is folded back into the taps
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    // State register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/pipe_engine.sv
// rtl/pipe_engine.sv - pipe scrolling, collision detection and scoring for Flappy Bird
module pipe_engine
    import flappy_pkg::*;
#(
    parameter int          SPEED     = 4,
    parameter int          PIPE_W    = 60,
    parameter int          GAP_H     = 120,
    parameter int          SPACING   = 320,
    parameter int          BIRD_SIZE = 20,
    parameter int          CEIL_Y    = 40,
    parameter int          FLOOR_Y   = 465,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       run,
    input  logic       pause,
    input  logic       restart,
    input  logic [9:0] bird_x,
    input  logic [8:0] bird_y,
    output logic [9:0] pipe0_x,
    output logic [9:0] pipe1_x,
    output logic [8:0] pipe0_gap,
    output logic [8:0] pipe1_gap,
    output logic       game_over,
    output logic       score_pulse,
    output logic [9:0] current_score,
    output logic [9:0] highest_score
);

    localparam logic [10:0] SPEED_X   = 11'(SPEED);
    localparam logic [10:0] RESPAWN_X = 11'(2 * SPACING);
    localparam logic [10:0] OVL_X     = 11'(BIRD_SIZE + PIPE_W);
    localparam logic [9:0]  BIRD_V    = 10'(BIRD_SIZE);
    localparam logic [9:0]  CEIL_V    = 10'(CEIL_Y);
    localparam logic [9:0]  FLOOR_V   = 10'(FLOOR_Y);
    localparam logic [9:0]  HALF_GAP  = 10'(GAP_H / 2);
    localparam logic [9:0]  SPAWN0_X  = 10'(SPAWN_X);
    localparam logic [9:0]  SPAWN1_X  = 10'(SPAWN_X + SPACING);
    localparam logic [8:0]  GAP0      = 9'(INIT_GAP);
    localparam logic [9:0]  SCORE_TOP = 10'(SCORE_MAX);

    state_t            state_q, state_d;
    logic [1:0][9:0]   px_q, px_d;
    logic [1:0][8:0]   gap_q, gap_d;
    logic [9:0]        score_q, score_d;
    logic [9:0]        high_q, high_d;
    logic              pulse_q, pulse_d;

    logic [15:0]       lfsr_q;
    logic [1:0][9:0]   step_x;
    logic [1:0]        respawn;
    logic [1:0]        passed;
    logic [1:0]        x_ov;
    logic [1:0]        pipe_hit;
    logic              wall_hit;
    logic              collide;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_q (lfsr_q)
    );

    // Collision test on the registered pipes against the current bird box
    always_comb begin
        x_ov     = '0;
        pipe_hit = '0;
        wall_hit = ({1'b0, bird_y} <= CEIL_V) || (({1'b0, bird_y} + BIRD_V) > FLOOR_V);
        for (int i = 0; i < 2; i++) begin
            x_ov[i] = ({1'b0, bird_x} < {1'b0, px_q[i]})
                   && (({1'b0, bird_x} + OVL_X) > {1'b0, px_q[i]});
            pipe_hit[i] = x_ov[i]
                       && (({1'b0, bird_y} < ({1'b0, gap_q[i]} - HALF_GAP))
                        || (({1'b0, bird_y} + BIRD_V) > ({1'b0, gap_q[i]} + HALF_GAP)));
        end
        collide = !pause && (wall_hit || (|pipe_hit));
    end

    // Candidate scroll position per pipe, wrapping back by two spacings once past the left edge
    always_comb begin
        step_x  = '0;
        respawn = '0;
        passed  = '0;
        for (int i = 0; i < 2; i++) begin
            respawn[i] = ({1'b0, px_q[i]} < SPEED_X);
            if (respawn[i]) begin
                step_x[i] = 10'({1'b0, px_q[i]} - SPEED_X + RESPAWN_X);
            end else begin
                step_x[i] = 10'({1'b0, px_q[i]} - SPEED_X);
            end
            passed[i] = (px_q[i] >= bird_x) && (step_x[i] < bird_x);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a falling run flag during play is deliberately ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run)     state_d = RUN;
            RUN:     if (collide) state_d = DEAD;
            DEAD:    if (restart) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // State-derived outputs
    always_comb begin
        game_over = (state_q == DEAD);
    end

    // Datapath update: spawn in IDLE, scroll and score on an unpaused collision-free tick
    always_comb begin
        px_d    = px_q;
        gap_d   = gap_q;
        score_d = score_q;
        high_d  = high_q;
        pulse_d = 1'b0;
        if ((state_q == IDLE) || ((state_q == DEAD) && restart)) begin
            px_d[0]  = SPAWN0_X;
            px_d[1]  = SPAWN1_X;
            gap_d[0] = GAP0;
            gap_d[1] = GAP0;
            score_d  = '0;
        end else if ((state_q == RUN) && tick && !pause && !collide) begin
            for (int i = 0; i < 2; i++) begin
                px_d[i] = step_x[i];
                if (respawn[i]) begin
                    gap_d[i] = gap_from_lfsr(lfsr_q[7:0]);
                end
            end
            if (|passed) begin
                pulse_d = 1'b1;
                score_d = (score_q >= SCORE_TOP) ? SCORE_TOP : score_q + 10'd1;
                if (score_d > high_q) begin
                    high_d = score_d;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            px_q[0]  <= SPAWN0_X;
            px_q[1]  <= SPAWN1_X;
            gap_q[0] <= GAP0;
            gap_q[1] <= GAP0;
            score_q  <= '0;
            high_q   <= '0;
            pulse_q  <= 1'b0;
        end else begin
            px_q    <= px_d;
            gap_q   <= gap_d;
            score_q <= score_d;
            high_q  <= high_d;
            pulse_q <= pulse_d;
        end
    end

    assign pipe0_x       = px_q[0];
    assign pipe1_x       = px_q[1];
    assign pipe0_gap     = gap_q[0];
    assign pipe1_gap     = gap_q[1];
    assign score_pulse   = pulse_q;
    assign current_score = score_q;
    assign highest_score = high_q;

endmodule

// File: tb/tb_pipe_engine.sv
// tb/tb_pipe_engine.sv - self-checking bench for pipe_engine with a behavioural game model
module tb_pipe_engine;

    localparam int P_SPEED = 4;
    localparam int P_PIPEW = 60;
    localparam int P_GAPH  = 120;
    localparam int P_SPACE = 320;
    localparam int P_BIRD  = 20;
    localparam int P_CEIL  = 40;
    localparam int P_FLOOR = 465;

    logic       clk = 1'b0;
    logic       reset, tick, run, pause, restart;
    logic [9:0] bird_x;
    logic [8:0] bird_y;
    logic [9:0] pipe0_x, pipe1_x, current_score, highest_score;
    logic [8:0] pipe0_gap, pipe1_gap;
    logic       game_over, score_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 idle, 1 playing, 2 crashed
    int          m_state, m_score, m_high;
    int          m_x[2];
    int          m_gap[2];
    bit          m_pulse, m_resp0;
    logic [15:0] m_lfsr;

    pipe_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .pause(pause), .restart(restart),
        .bird_x(bird_x), .bird_y(bird_y),
        .pipe0_x(pipe0_x), .pipe1_x(pipe1_x), .pipe0_gap(pipe0_gap), .pipe1_gap(pipe1_gap),
        .game_over(game_over), .score_pulse(score_pulse),
        .current_score(current_score), .highest_score(highest_score)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic int gap_of(input logic [15:0] l);
        int g;
        g = int'(l & 16'h00FF);
        return (g < 240) ? 120 + g : 120 + g - 128;
    endfunction

    function automatic bit m_collide();
        int bx, by;
        bx = int'(bird_x);
        by = int'(bird_y);
        if (by <= P_CEIL || by + P_BIRD > P_FLOOR) return 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (bx < m_x[i] && bx + P_BIRD > m_x[i] - P_PIPEW &&
                (by < m_gap[i] - P_GAPH / 2 || by + P_BIRD > m_gap[i] + P_GAPH / 2))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // a bird height that clears whichever pipe currently overlaps the bird column
    function automatic int safe_y();
        for (int i = 0; i < 2; i++) begin
            if (int'(bird_x) < m_x[i] && int'(bird_x) + P_BIRD > m_x[i] - P_PIPEW)
                return m_gap[i] - 10;
        end
        return 230;
    endfunction

    task automatic spawn_model(output int x[2], output int g[2]);
        x[0] = 640;
        x[1] = 640 + P_SPACE;
        g[0] = 240;
        g[1] = 240;
    endtask

    // one clock: model decides from the current inputs, then both advance together
    task automatic step();
        int nx[2], ng[2];
        int ns, nsc, nh, old;
        bit np, pass, r0;
        ns = m_state; nx = m_x; ng = m_gap; nsc = m_score; nh = m_high; np = 0; r0 = 0;
        if (reset) begin
            ns = 0; spawn_model(nx, ng); nsc = 0; nh = 0;
        end else if (m_state == 0) begin
            spawn_model(nx, ng); nsc = 0;
            if (run) ns = 1;
        end else if (m_state == 1) begin
            if (!pause && m_collide()) begin
                ns = 2;
            end else if (tick && !pause) begin
                pass = 0;
                for (int i = 0; i < 2; i++) begin
                    old = m_x[i];
                    if (old >= P_SPEED) nx[i] = old - P_SPEED;
                    else begin
                        nx[i] = (old - P_SPEED + 2 * P_SPACE) % 2048;
                        ng[i] = gap_of(m_lfsr);
                        if (i == 0) r0 = 1;
                    end
                    if (old >= int'(bird_x) && nx[i] < int'(bird_x)) pass = 1;
                end
                if (pass) begin
                    nsc = (m_score + 1 > 999) ? 999 : m_score + 1;
                    np = 1;
                    if (nsc > m_high) nh = nsc;
                end
            end
        end else if (restart) begin
            ns = 0; spawn_model(nx, ng); nsc = 0;
        end
        @(posedge clk);
        m_state = ns; m_x = nx; m_gap = ng; m_score = nsc; m_high = nh; m_pulse = np; m_resp0 = r0;
        m_lfsr = reset ? 16'hACE1 : lfsr_next(m_lfsr);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; step(); step();
        reset = 0; step();
        n_tests++;
        if ({pipe0_x, pipe1_x, pipe0_gap, pipe1_gap} !== {10'd640, 10'd960, 9'd240, 9'd240}) begin
            n_fail++;
            $display("FAIL reset_pipes: got %0d %0d %0d %0d expected 640 960 240 240", pipe0_x, pipe1_x, pipe0_gap, pipe1_gap);
        end
        n_tests++;
        if ({current_score, highest_score, score_pulse, game_over} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got score %0d high %0d pulse %b over %b expected all 0", current_score, highest_score, score_pulse, game_over);
        end
    endtask

    task automatic test_first_tick();
        bird_x = 10'd140; bird_y = 9'd230;
        run = 1; step();
        tick = 1; step(); tick = 0;
        n_tests++;
        if ({pipe0_x, pipe1_x, game_over, current_score} !== {10'd636, 10'd956, 1'b0, 10'd0}) begin
            n_fail++;
            $display("FAIL first_tick: got x0 %0d x1 %0d over %b score %0d expected 636 956 0 0", pipe0_x, pipe1_x, game_over, current_score);
        end
    endtask

    task automatic test_random_play();
        logic [59:0] exp_v, got_v;
        bit resp_seen = 0;
        bird_x = 10'($urandom_range(100, 400));
        for (int c = 0; c < 800; c++) begin
            tick    = ($urandom_range(0, 3) != 0);
            pause   = ($urandom_range(0, 9) == 0);
            run     = $urandom_range(0, 1);
            restart = ($urandom_range(0, 15) == 0);
            bird_y  = 9'(safe_y());
            step();
            exp_v = {10'(m_x[0]), 10'(m_x[1]), 9'(m_gap[0]), 9'(m_gap[1]),
                     10'(m_score), 10'(m_high), m_pulse, (m_state == 2)};
            got_v = {pipe0_x, pipe1_x, pipe0_gap, pipe1_gap,
                     current_score, highest_score, score_pulse, game_over};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
            if (m_resp0 && !resp_seen) begin
                resp_seen = 1;
                n_tests++;
                if (pipe0_x !== 10'd636 || pipe0_gap < 9'd120 || pipe0_gap > 9'd359) begin
                    n_fail++;
                    $display("FAIL respawn: got x %0d gap %0d expected 636 and 120..359", pipe0_x, pipe0_gap);
                end
            end
        end
        tick = 0; pause = 0; run = 0; restart = 0;
    endtask

    task automatic test_wall_restart();
        bird_x = 10'd140; bird_y = 9'd446;
        step();
        n_tests++;
        if (game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL floor_hit: got over %b expected 1", game_over);
        end
        bird_y = 9'd230; restart = 1; step(); restart = 0;
        n_tests++;
        if ({game_over, current_score, pipe0_x, highest_score} !== {1'b0, 10'd0, 10'd640, 10'(m_high)}) begin
            n_fail++;
            $display("FAIL restart: got over %b score %0d x0 %0d high %0d expected 0 0 640 %0d", game_over, current_score, pipe0_x, highest_score, m_high);
        end
    endtask

    task automatic test_boundaries();
        tick = 1; step(); tick = 0;
        n_tests++;
        if (pipe0_x !== 10'd640) begin
            n_fail++;
            $display("FAIL idle_tick: got x0 %0d expected 640", pipe0_x);
        end
        run = 1; step(); run = 0;
        bird_y = 9'd445; step();
        n_tests++;
        if (game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL floor_edge: got over %b expected 0", game_over);
        end
        bird_y = 9'd41; step();
        n_tests++;
        if (game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL ceil_edge: got over %b expected 0", game_over);
        end
        bird_y = 9'd40; step();
        n_tests++;
        if (game_over !== 1'b1) begin
            n_fail++;
            $display("FAIL ceil_hit: got over %b expected 1", game_over);
        end
        bird_y = 9'd230; restart = 1; step(); restart = 0;
    endtask

    task automatic test_pipe_collision();
        run = 1; step(); run = 0;
        bird_x = 10'd140; bird_y = 9'd230;
        tick = 1;
        for (int t = 0; t < 122; t++) step();
        tick = 0;
        n_tests++;
        if (pipe0_x !== 10'd152 || pipe0_gap !== 9'd240 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL approach: got x0 %0d gap %0d over %b expected 152 240 0", pipe0_x, pipe0_gap, game_over);
        end
        bird_y = 9'd200; step();
        n_tests++;
        if (game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL in_gap: got over %b expected 0", game_over);
        end
        bird_y = 9'd170; tick = 1; step(); tick = 0;
        n_tests++;
        if ({game_over, pipe0_x, pipe1_x, current_score} !== {1'b1, 10'd152, 10'd472, 10'd0}) begin
            n_fail++;
            $display("FAIL pipe_hit: got over %b x0 %0d x1 %0d score %0d expected 1 152 472 0", game_over, pipe0_x, pipe1_x, current_score);
        end
        bird_y = 9'd230; restart = 1; step(); restart = 0;
    endtask

    task automatic test_pause();
        run = 1; step(); run = 0;
        tick = 1;
        for (int t = 0; t < 20; t++) begin bird_y = 9'(safe_y()); step(); end
        pause = 1; bird_y = 9'd30;
        for (int t = 0; t < 10; t++) step();
        n_tests++;
        if ({pipe0_x, pipe1_x, current_score, game_over} !== {10'd560, 10'd880, 10'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL pause_hold: got x0 %0d x1 %0d score %0d over %b expected 560 880 0 0", pipe0_x, pipe1_x, current_score, game_over);
        end
        pause = 0; tick = 0; bird_y = 9'(safe_y()); step();
    endtask

    task automatic test_reset_mid_run();
        int budget = 3000;
        tick = 1; bird_x = 10'd140;
        while (m_score < 5 && budget > 0) begin
            bird_y = 9'(safe_y()); step(); budget--;
        end
        tick = 0;
        n_tests++;
        if (budget == 0 || current_score !== 10'd5) begin
            n_fail++;
            $display("FAIL reach_score5: got score %0d budget %0d expected 5 before budget ran out", current_score, budget);
        end
        reset = 1; step(); reset = 0;
        n_tests++;
        if ({pipe0_x, pipe1_x, pipe0_gap, pipe1_gap, current_score, highest_score, score_pulse, game_over}
            !== {10'd640, 10'd960, 9'd240, 9'd240, 10'd0, 10'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %0d %0d %0d %0d score %0d high %0d pulse %b over %b expected 640 960 240 240 0 0 0 0",
                     pipe0_x, pipe1_x, pipe0_gap, pipe1_gap, current_score, highest_score, score_pulse, game_over);
        end
    endtask

    initial begin
        reset = 1; tick = 0; run = 0; pause = 0; restart = 0;
        bird_x = 10'd140; bird_y = 9'd230;
        m_state = 0; m_score = 0; m_high = 0; m_pulse = 0; m_resp0 = 0; m_lfsr = 16'hACE1;
        m_x[0] = 640; m_x[1] = 960; m_gap[0] = 240; m_gap[1] = 240;
        test_reset();
        test_first_tick();
        test_random_play();
        test_wall_restart();
        test_boundaries();
        test_pipe_collision();
        test_pause();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
